video_seg_packetizer: RTL and testbench

- Successor to the fixed 640-pixel, two-word-header pixel inserter that feeds the camera FIFO and UDP MAC path.
- Accepts a raw CMOS pixel stream and splits each line into segments of at most PKT_PIX pixels.
- Prefixes each segment with HDR_WORDS header words: SYNC_CODE for the first segment of a frame, the segment index otherwise.
- Buffers payload in an internal FIFO and emits framed packets on a ready/valid stream with sop/eop; output backpressure is supported, and whole segments are dropped on overflow.

---
 rtl/video_seg_packetizer_if.sv | 41 ++++
 rtl/video_seg_packetizer.sv | 226 ++++++++++++++++++++++
 tb/tb_video_seg_packetizer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_seg_packetizer_if.sv
// ---------------------------------------------------------------------------
// video_seg_packetizer_if
// Purpose : groups the pixel input stream and the framed packet output stream
//           of video_seg_packetizer.
// Signals : vsync_in  - frame sync, high during vertical blanking
//           href_in   - pixel valid
//           data_in   - pixel data
//           out_data  - packet word (header or pixel)
//           out_valid - out_data valid
//           out_ready - downstream accepts the word
//           out_sop   - first header word of a packet
//           out_eop   - last payload word of a packet
// Handshake: a word transfers on a rising clock edge where
//           out_valid && out_ready. Once out_valid is high, out_data, out_sop
//           and out_eop stay unchanged and out_valid stays high until that
//           transfer happens. out_ready may change freely.
// ---------------------------------------------------------------------------
interface video_seg_packetizer_if #(
    parameter int DATA_W = 16
);
    logic              vsync_in;
    logic              href_in;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_sop;
    logic              out_eop;

    // packetizer side
    modport master (
        input  vsync_in, href_in, data_in, out_ready,
        output out_data, out_valid, out_sop, out_eop
    );

    // camera source + downstream sink side
    modport slave (
        output vsync_in, href_in, data_in, out_ready,
        input  out_data, out_valid, out_sop, out_eop
    );
endinterface

// File: rtl/video_seg_packetizer.sv
// ---------------------------------------------------------------------------
// video_seg_packetizer
// Purpose : splits each CMOS line into segments of at most PKT_PIX pixels,
//           buffers them in a payload FIFO and emits packets made of
//           HDR_WORDS header words (SYNC_CODE for the first segment of a
//           frame, the segment index otherwise) followed by the pixels.
//           Segments that would not fit in the FIFO are dropped whole.
// Ports   : sys_clk   - pixel clock, all logic on the rising edge
//           reset     - asynchronous, active-high
//           bus       - pixel input and packet output stream (master modport)
//           overflow  - sticky, a segment was dropped since the last vsync
//           drop_cnt  - dropped segments, saturating, cleared by reset only
//           dbg_state - current read FSM state (IDLE=0, HDR=1, PAY=2)
// ---------------------------------------------------------------------------
module video_seg_packetizer #(
    parameter int                DATA_W    = 16,
    parameter int                PKT_PIX   = 640,
    parameter int                HDR_WORDS = 2,
    parameter logic [DATA_W-1:0] SYNC_CODE = DATA_W'(16'hA55A),
    parameter int                FIFO_AW   = 11,
    parameter int                IDX_W     = 16
) (
    input  logic                   sys_clk,
    input  logic                   reset,
    video_seg_packetizer_if.master bus,
    output logic                   overflow,
    output logic [15:0]            drop_cnt,
    output logic [1:0]             dbg_state
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CNT_W = FIFO_AW + 1;
    localparam int SEG_W = $clog2(PKT_PIX + 1);
    localparam int HC_W  = (HDR_WORDS > 1) ? $clog2(HDR_WORDS) : 1;
    localparam int ENT_W = DATA_W + 2;

    typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, PAY = 2'd2} state_t;

    // ---------------- write side ----------------
    logic              hold_valid, hold_sof, hold_drop, frame_pend;
    logic [DATA_W-1:0] hold_data;
    logic [SEG_W-1:0]  hold_cnt;
    logic              pix, seg_start, hold_eos, fifo_wr, start_drop;
    logic [CNT_W-1:0]  free_words;

    // FIFO storage; each entry is {sof, eos, pixel}
    logic [ENT_W-1:0]   mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   fifo_cnt;
    logic               pop;

    assign pix       = bus.href_in && !bus.vsync_in;
    // a new segment begins on href rise or right after a full segment
    assign seg_start = pix && (!hold_valid || hold_cnt == SEG_W'(PKT_PIX));
    // the held pixel closes its segment when the segment is full or the
    // stream stops (href low or vsync high) in the current cycle
    assign hold_eos  = (hold_cnt == SEG_W'(PKT_PIX)) || !pix;
    assign fifo_wr   = hold_valid && !hold_drop;
    // the pending write of the held pixel is charged before admitting a new
    // segment so a full segment is guaranteed to fit; reads are not credited
    assign free_words = CNT_W'(DEPTH) - fifo_cnt - CNT_W'(fifo_wr);
    assign start_drop = free_words < CNT_W'(PKT_PIX);

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
            hold_cnt   <= '0;
            hold_sof   <= 1'b0;
            hold_drop  <= 1'b0;
            frame_pend <= 1'b0;
            overflow   <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            hold_valid <= pix;
            if (pix) begin
                hold_data <= bus.data_in;
                if (seg_start) begin
                    hold_cnt  <= SEG_W'(1);
                    hold_sof  <= frame_pend;
                    hold_drop <= start_drop;
                end else begin
                    hold_cnt <= hold_cnt + SEG_W'(1);
                end
            end
            // a dropped sof segment leaves frame_pend set for the next one
            if (bus.vsync_in)
                frame_pend <= 1'b1;
            else if (seg_start && !start_drop)
                frame_pend <= 1'b0;
            if (bus.vsync_in)
                overflow <= 1'b0;
            else if (seg_start && start_drop)
                overflow <= 1'b1;
            if (seg_start && start_drop && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (fifo_wr)
            mem[wr_ptr] <= {hold_sof, hold_eos, hold_data};
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifo_wr)
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            fifo_cnt <= fifo_cnt + CNT_W'(fifo_wr) - CNT_W'(pop);
        end
    end

    // ---------------- read side ----------------
    logic [ENT_W-1:0]  head;
    logic              head_sof, head_eos, fifo_ne, hs;
    logic [DATA_W-1:0] head_data;

    assign head      = mem[rd_ptr];
    assign head_sof  = head[ENT_W-1];
    assign head_eos  = head[ENT_W-2];
    assign head_data = head[DATA_W-1:0];
    assign fifo_ne   = fifo_cnt != '0;

    state_t            state, state_nx;
    logic [HC_W-1:0]   hdr_cnt, hdr_cnt_nx;
    logic              valid_q, valid_nx, sop_q, sop_nx, eop_q, eop_nx;
    logic              cur_sof, cur_sof_nx;
    logic [DATA_W-1:0] data_q, data_nx;
    logic [IDX_W-1:0]  seg_idx, seg_idx_nx;

    assign hs = valid_q && bus.out_ready;

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            hdr_cnt <= '0;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            data_q  <= '0;
            cur_sof <= 1'b0;
            seg_idx <= '0;
        end else begin
            state   <= state_nx;
            hdr_cnt <= hdr_cnt_nx;
            valid_q <= valid_nx;
            sop_q   <= sop_nx;
            eop_q   <= eop_nx;
            data_q  <= data_nx;
            cur_sof <= cur_sof_nx;
            seg_idx <= seg_idx_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        hdr_cnt_nx = hdr_cnt;
        valid_nx   = valid_q;
        sop_nx     = sop_q;
        eop_nx     = eop_q;
        data_nx    = data_q;
        cur_sof_nx = cur_sof;
        seg_idx_nx = seg_idx;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_ne) begin
                    state_nx   = HDR;
                    hdr_cnt_nx = '0;
                    valid_nx   = 1'b1;
                    sop_nx     = 1'b1;
                    eop_nx     = 1'b0;
                    cur_sof_nx = head_sof;
                    data_nx    = head_sof ? SYNC_CODE : DATA_W'(seg_idx);
                end
            end
            HDR: begin
                if (hs) begin
                    sop_nx = 1'b0;
                    if (hdr_cnt == HC_W'(HDR_WORDS - 1)) begin
                        // the head entry is this segment's first pixel, so it
                        // is always present here
                        state_nx = PAY;
                        data_nx  = head_data;
                        eop_nx   = head_eos;
                        pop      = 1'b1;
                    end else begin
                        hdr_cnt_nx = hdr_cnt + HC_W'(1);
                    end
                end
            end
            PAY: begin
                if (hs && eop_q) begin
                    state_nx   = IDLE;
                    valid_nx   = 1'b0;
                    eop_nx     = 1'b0;
                    seg_idx_nx = cur_sof ? IDX_W'(1) : seg_idx + IDX_W'(1);
                end else if (hs || !valid_q) begin
                    // the output register is free; refill it if the rest of
                    // the segment has been written, otherwise wait
                    if (fifo_ne) begin
                        valid_nx = 1'b1;
                        data_nx  = head_data;
                        eop_nx   = head_eos;
                        pop      = 1'b1;
                    end else begin
                        valid_nx = 1'b0;
                        eop_nx   = 1'b0;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_sop   = sop_q;
    assign bus.out_eop   = eop_q;
    assign dbg_state     = state;
endmodule

// File: tb/tb_video_seg_packetizer.sv
`timescale 1ns/1ps
module tb_video_seg_packetizer;
    localparam int          DATA_W    = 16;
    localparam int          PKT_PIX   = 640;
    localparam int          HDR_WORDS = 2;
    localparam int          FIFO_AW   = 10;
    localparam int          IDX_W     = 16;
    localparam int          DEPTH     = 1 << FIFO_AW;
    localparam logic [15:0] SYNC      = 16'hA55A;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    video_seg_packetizer_if #(.DATA_W(DATA_W)) vif();

    logic ready_mode = 1'b0;
    logic ready_rand = 1'b1;
    logic ready_fixed;
    assign vif.out_ready = ready_mode ? ready_rand : ready_fixed;

    always @(posedge clk) begin
        #1;
        ready_rand = ($urandom_range(0, 1) == 1);
    end

    video_seg_packetizer #(
        .DATA_W(DATA_W), .PKT_PIX(PKT_PIX), .HDR_WORDS(HDR_WORDS),
        .SYNC_CODE(SYNC), .FIFO_AW(FIFO_AW), .IDX_W(IDX_W)
    ) dut (
        .sys_clk(clk),
        .reset(rst),
        .bus(vif),
        .overflow(overflow),
        .drop_cnt(drop_cnt),
        .dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [DATA_W+1:0] exp_q[$];   // {sop, eop, data}
    int                n_checks = 0;
    int                n_pass   = 0;
    int                rx_words = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, got, expv);
    endtask

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] line_px[$];
    logic              m_frame_pend = 1'b0;
    logic [15:0]       m_idx        = 16'd0;
    logic              m_overflow   = 1'b0;
    int                m_drops      = 0;
    logic              m_noread     = 1'b0;   // downstream held off: FIFO only fills
    int                m_occ        = 0;

    // Cuts the current line into segments and queues the packets they become.
    task automatic model_line();
        int   pos, len;
        logic sof;
        pos = 0;
        while (pos < line_px.size()) begin
            len = line_px.size() - pos;
            if (len > PKT_PIX) len = PKT_PIX;
            sof = m_frame_pend;
            if (m_noread && (DEPTH - m_occ) < PKT_PIX) begin
                m_overflow = 1'b1;
                if (m_drops < 65535) m_drops++;
            end else begin
                for (int h = 0; h < HDR_WORDS; h++)
                    exp_q.push_back({(h == 0), 1'b0, (sof ? SYNC : m_idx)});
                for (int i = 0; i < len; i++)
                    exp_q.push_back({1'b0, (i == len - 1), line_px[pos + i]});
                if (m_noread) m_occ += len;
                if (sof) begin
                    m_frame_pend = 1'b0;
                    m_idx        = 16'd1;
                end else begin
                    m_idx = m_idx + 16'd1;
                end
            end
            pos += len;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_line(input int n, input bit rnd, input int gap);
        line_px.delete();
        for (int i = 0; i < n; i++)
            line_px.push_back(rnd ? DATA_W'($urandom) : DATA_W'(i));
        model_line();
        for (int i = 0; i < n; i++) begin
            vif.href_in = 1'b1;
            vif.data_in = line_px[i];
            @(posedge clk); #1;
        end
        vif.href_in = 1'b0;
        vif.data_in = '0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic do_vsync();
        vif.vsync_in = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        vif.vsync_in = 1'b0;
        m_frame_pend = 1'b1;
        m_overflow   = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((exp_q.size() != 0 || vif.out_valid) && k < 6000) begin
            @(posedge clk); #1;
            k++;
        end
        chk("drain_all_words", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- monitor ----------------
    logic              stall_prev = 1'b0;
    logic [DATA_W+1:0] stall_word;

    always @(negedge clk) begin
        logic [DATA_W+1:0] got, expw;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            got = {vif.out_sop, vif.out_eop, vif.out_data};
            if (stall_prev)
                chk("stall_hold", {13'd0, vif.out_valid, got}, {13'd0, 1'b1, stall_word});
            if (vif.out_valid && vif.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_word: got %0h required none", got);
                end else begin
                    expw = exp_q.pop_front();
                    chk("stream_word", 32'(got), 32'(expw));
                end
                rx_words++;
            end
            stall_prev = vif.out_valid && !vif.out_ready;
            stall_word = got;
        end
    end

    // ---------------- stimulus ----------------
    int   base;
    logic reached;
    logic lat_ok;

    initial begin
        rst          = 1'b1;
        vif.vsync_in = 1'b0;
        vif.href_in  = 1'b0;
        vif.data_in  = '0;
        ready_fixed  = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_out_valid", 32'(vif.out_valid), 32'd0);
        chk("rst_out_sop",   32'(vif.out_sop),   32'd0);
        chk("rst_out_eop",   32'(vif.out_eop),   32'd0);
        chk("rst_out_data",  32'(vif.out_data),  32'd0);
        chk("rst_overflow",  32'(overflow),      32'd0);
        chk("rst_drop_cnt",  32'(drop_cnt),      32'd0);

        // one 1280-pixel line split into two full segments
        do_vsync();
        send_line(1280, 1'b0, 20);
        wait_drain();

        // 700-pixel line, then a 1-pixel line with first-header latency check
        do_vsync();
        send_line(700, 1'b0, 20);
        wait_drain();
        line_px.delete();
        line_px.push_back(DATA_W'($urandom));
        model_line();
        vif.href_in = 1'b1;
        vif.data_in = line_px[0];
        @(posedge clk); #1;
        vif.href_in = 1'b0;
        lat_ok = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            if (vif.out_valid) lat_ok = 1'b1;
        end
        chk("first_hdr_latency", 32'(lat_ok), 32'd1);
        wait_drain();

        // random backpressure over three random-length lines
        ready_mode = 1'b1;
        do_vsync();
        for (int l = 0; l < 3; l++) begin
            send_line($urandom_range(1, 700), 1'b1, $urandom_range(5, 30));
            wait_drain();
        end
        ready_mode = 1'b0;
        @(posedge clk); #1;

        // two frames of two 1280-pixel lines
        for (int f = 0; f < 2; f++) begin
            do_vsync();
            for (int l = 0; l < 2; l++) send_line(1280, 1'b1, 20);
        end
        wait_drain();

        // overflow: downstream held off across three full-segment lines
        m_noread    = 1'b1;
        m_occ       = 0;
        ready_fixed = 1'b0;
        do_vsync();
        for (int l = 0; l < 3; l++) send_line(640, 1'b0, 20);
        repeat (5) begin @(posedge clk); #1; end
        chk("ovf_overflow",  32'(overflow), 32'(m_overflow));
        chk("ovf_drop_cnt",  32'(drop_cnt), 32'(m_drops));
        chk("ovf_head_sop",  32'(vif.out_sop), 32'd1);
        ready_fixed = 1'b1;
        m_noread    = 1'b0;
        wait_drain();
        do_vsync();
        chk("ovf_cleared",   32'(overflow), 32'(m_overflow));
        chk("ovf_drop_keep", 32'(drop_cnt), 32'(m_drops));

        // asynchronous reset in the middle of a payload
        base    = rx_words;
        reached = 1'b0;
        fork
            send_line(640, 1'b0, 20);
            begin
                for (int k = 0; k < 3000 && !reached; k++) begin
                    @(posedge clk);
                    if (rx_words - base >= HDR_WORDS + 300) reached = 1'b1;
                end
                #3 rst = 1'b1;
                exp_q.delete();
                #1;
                chk("mid_reset_reached", 32'(reached), 32'd1);
                chk("mid_rst_out_valid", 32'(vif.out_valid), 32'd0);
                chk("mid_rst_out_sop",   32'(vif.out_sop),   32'd0);
                chk("mid_rst_out_eop",   32'(vif.out_eop),   32'd0);
                chk("mid_rst_out_data",  32'(vif.out_data),  32'd0);
                chk("mid_rst_overflow",  32'(overflow),      32'd0);
                chk("mid_rst_drop_cnt",  32'(drop_cnt),      32'd0);
            end
        join
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        m_frame_pend = 1'b0;
        m_idx        = 16'd0;
        m_overflow   = 1'b0;
        m_drops      = 0;
        do_vsync();
        send_line(100, 1'b1, 20);
        wait_drain();

        repeat (5) begin @(posedge clk); #1; end
        chk("end_idle", 32'(vif.out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
